// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch stage that owns the fetch PC, issues in-order imem
// requests and buffers {pc, instr} pairs for decode in a DEPTH-entry queue.
// A redirect retargets fetch, flushes the queue and discards in-flight data.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]    fetch_pc;
  logic [31:0]    slot_pc    [DEPTH];
  logic [31:0]    slot_instr [DEPTH];
  logic [DEPTH-1:0] slot_filled;
  logic [PW-1:0]  alloc_ptr;
  logic [PW-1:0]  fill_ptr;
  logic [PW-1:0]  head_ptr;
  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  drop_cnt;
  logic [CW-1:0]  used;

  logic           issue;
  logic           pop;
  logic           rsp_drop;
  logic           rsp_fill;
  logic [CW-1:0]  redirect_drop;

  assign imem_req_addr = fetch_pc;
  assign if_valid      = slot_filled[head_ptr];
  assign if_pc         = slot_pc[head_ptr];
  assign if_instr      = slot_instr[head_ptr];

  // Handshake qualification and the drop count a redirect leaves behind.
  always_comb begin
    imem_req_valid = !reset && !redirect && (used < CW'(DEPTH));
    issue          = imem_req_valid && imem_req_ready;
    pop            = if_valid && if_ready && !redirect;
    rsp_drop       = imem_rsp_valid && (drop_cnt != '0);
    rsp_fill       = imem_rsp_valid && (drop_cnt == '0) && (outstanding != '0);
    // Everything in flight becomes garbage; a response landing in the
    // redirect cycle is one of those and is consumed right here.
    redirect_drop  = drop_cnt + outstanding
                   - CW'(imem_rsp_valid && ((drop_cnt != '0) || (outstanding != '0)));
  end

  // Fetch PC, queue slots, pointers and in-flight bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      slot_filled <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_pc[i]    <= '0;
        slot_instr[i] <= '0;
      end
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      head_ptr    <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      used        <= '0;
    end else if (redirect) begin
      fetch_pc    <= redirect_pc;
      slot_filled <= '0;
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      head_ptr    <= '0;
      outstanding <= '0;
      drop_cnt    <= redirect_drop;
      used        <= '0;
    end else begin
      if (issue) begin
        slot_pc[alloc_ptr]     <= fetch_pc;
        slot_filled[alloc_ptr] <= 1'b0;
        alloc_ptr              <= alloc_ptr + PW'(1);
        fetch_pc               <= fetch_pc + 32'd4;
      end
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      // Fill, alloc and head slots never coincide: fill targets an
      // allocated-but-empty slot, alloc a free one, head a filled one.
      if (rsp_fill) begin
        slot_instr[fill_ptr]  <= imem_rsp_data;
        slot_filled[fill_ptr] <= 1'b1;
        fill_ptr              <= fill_ptr + PW'(1);
      end
      if (pop) begin
        slot_filled[head_ptr] <= 1'b0;
        head_ptr              <= head_ptr + PW'(1);
      end
      outstanding <= outstanding + CW'(issue) - CW'(rsp_fill);
      used        <= used + CW'(issue) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed and stress stimulus for ifetch_queue with an
// in-order variable-latency memory model and a scoreboard of expected PCs.
module tb_ifetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'h5A5A_C3C3;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_instr(if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_issue = 0;
  int          n_pop = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          ready_mode = 0;  // 0 always ready, 1 never, 2 random
  bit          mon_en = 1'b0;
  mreq_t       memq [$];
  logic [31:0] expq [$];
  logic [31:0] next_fetch = RESET_PC;
  logic [31:0] rtab [4] = '{32'h0000_0800, 32'hFFFF_FFF8, 32'h0000_0102, 32'h1234_5670};

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ KEY;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst req_valid", 32'(imem_req_valid), 0);
    chk("rst req_addr", imem_req_addr, RESET_PC);
    chk("rst if_valid", 32'(if_valid), 0);
    chk("rst if_pc", if_pc, 0);
    chk("rst if_instr", if_instr, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; redirect = 1'b0; mon_en = 1'b1;
    @(negedge clk);
    chk_reset_state();
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = pc;
    @(posedge clk); #1;
    redirect = 1'b0;
  endtask

  task automatic wait_pop(input string name, input logic [31:0] pc, input logic [31:0] instr);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (if_valid && if_ready && !redirect) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s: no pop within 100 cycles, expected pc %h", name, pc);
    end else begin
      chk({name, " pc"}, if_pc, pc);
      chk({name, " instr"}, if_instr, instr);
    end
  endtask

  // Memory model: one in-order response per cycle once its due cycle arrives.
  initial begin
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (reset) begin
        memq.delete();
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      end else if (memq.size() > 0 && memq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(memq[0].addr);
        void'(memq.pop_front());
      end else begin
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      end
      case (ready_mode)
        0:       imem_req_ready = 1'b1;
        1:       imem_req_ready = 1'b0;
        default: imem_req_ready = ($urandom_range(3, 0) != 0);
      endcase
    end
  end

  // Monitor / scoreboard: sampled mid-cycle, events complete on the next edge.
  initial begin
    bit          post_redirect = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] exp_pc;
    forever begin
      @(negedge clk);
      if (!mon_en) continue;
      if (reset) begin
        expq.delete(); next_fetch = RESET_PC;
        post_redirect = 1'b0; prev_stall = 1'b0;
      end else begin
        if (post_redirect) chk("if_valid after redirect", 32'(if_valid), 0);
        chk("req_valid", 32'(imem_req_valid), 32'(!redirect && expq.size() < DEPTH));
        chk("no stale valid", 32'(if_valid && expq.size() == 0), 0);
        if (prev_stall && !redirect) begin
          chk("stall valid held", 32'(imem_req_valid), 1);
          chk("stall addr held", imem_req_addr, prev_addr);
        end
        if (if_valid && if_ready && !redirect && expq.size() > 0) begin
          exp_pc = expq.pop_front();
          chk("pop pc", if_pc, exp_pc);
          chk("pop instr", if_instr, mem_word(exp_pc));
          n_pop++;
        end
        if (imem_req_valid && imem_req_ready) begin
          chk("req addr", imem_req_addr, next_fetch);
          expq.push_back(next_fetch);
          memq.push_back('{addr: imem_req_addr,
                           due: cyc + int'($urandom_range(lat_max, lat_min))});
          next_fetch = next_fetch + 32'd4;
          n_issue++;
        end
        prev_stall    = imem_req_valid && !imem_req_ready;
        prev_addr     = imem_req_addr;
        post_redirect = redirect;
        if (redirect) begin
          expq.delete();
          next_fetch = redirect_pc;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int gap;
    reset = 1'b0; redirect = 1'b0; redirect_pc = '0; if_ready = 1'b1;

    // T1: streaming, 1-cycle memory, decode always ready
    lat_min = 1; lat_max = 1; ready_mode = 0; if_ready = 1'b1;
    do_reset();
    @(negedge clk);
    chk("t1 valid c0", 32'(imem_req_valid), 1);
    chk("t1 addr c0", imem_req_addr, 32'h0);
    @(negedge clk);
    chk("t1 addr c1", imem_req_addr, 32'h4);
    chk("t1 if_valid c1", 32'(if_valid), 0);
    @(negedge clk);
    chk("t1 if_valid c2", 32'(if_valid), 1);
    chk("t1 if_pc c2", if_pc, 32'h0);
    chk("t1 if_instr c2", if_instr, 32'h5A5A_C3C3);
    chk("t1 addr c2", imem_req_addr, 32'h8);
    @(negedge clk);
    chk("t1 if_pc c3", if_pc, 32'h4);
    chk("t1 if_instr c3", if_instr, 32'h5A5A_C3C7);
    #1 p0 = n_pop;
    repeat (10) @(negedge clk);
    #1 chk("t1 throughput", 32'(n_pop - p0), 10);

    // T2: decode stalled fills exactly DEPTH slots
    if_ready = 1'b0;
    do_reset();
    n_issue = 0;
    repeat (8) @(negedge clk);
    #1;
    chk("t2 issued", 32'(n_issue), 4);
    chk("t2 full valid", 32'(imem_req_valid), 0);
    chk("t2 if_valid", 32'(if_valid), 1);
    chk("t2 if_pc", if_pc, 32'h0);
    @(posedge clk); #1 if_ready = 1'b1;
    @(negedge clk);
    chk("t2 pop cycle valid", 32'(imem_req_valid), 0);
    @(negedge clk);
    chk("t2 refill valid", 32'(imem_req_valid), 1);
    chk("t2 refill addr", imem_req_addr, 32'h10);
    chk("t2 next pc", if_pc, 32'h4);
    repeat (6) @(negedge clk);

    // T3: redirect with 3 requests in flight
    lat_min = 6; lat_max = 6;
    do_reset();
    n_issue = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    @(negedge clk);
    #1 chk("t3 in flight", 32'(n_issue), 3);
    @(posedge clk); #1 redirect = 1'b0;
    wait_pop("t3 first", 32'h0000_0100, 32'h5A5A_C2C3);
    wait_pop("t3 second", 32'h0000_0104, 32'h5A5A_C2C7);

    // T3b: back-to-back redirects, last wins
    lat_min = 3; lat_max = 3;
    repeat (6) @(posedge clk);
    #1 redirect = 1'b1; redirect_pc = 32'h0000_0300;
    @(posedge clk); #1 redirect_pc = 32'h0000_0340;
    @(posedge clk); #1 redirect = 1'b0;
    wait_pop("t3b first", 32'h0000_0340, 32'h5A5A_C083);

    // T4: redirect coinciding with a response and a pop
    lat_min = 2; lat_max = 2;
    do_reset();
    repeat (7) @(posedge clk);
    #1 redirect = 1'b1; redirect_pc = 32'h0000_0200;
    @(negedge clk);
    chk("t4 rsp present", 32'(imem_rsp_valid), 1);
    chk("t4 head present", 32'(if_valid), 1);
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    chk("t4 if_valid after", 32'(if_valid), 0);
    wait_pop("t4 first", 32'h0000_0200, 32'h5A5A_C1C3);
    wait_pop("t4 second", 32'h0000_0204, 32'h5A5A_C1C7);

    // T5: request stall holds address; redirect during stall
    lat_min = 1; lat_max = 1;
    @(posedge clk); #1;
    ready_mode = 1; redirect = 1'b1; redirect_pc = 32'h0000_0020;
    @(posedge clk); #1 redirect = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5 stall valid", 32'(imem_req_valid), 1);
      chk("t5 stall addr", imem_req_addr, 32'h0000_0020);
    end
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'h0000_0040;
    @(posedge clk); #1 redirect = 1'b0; ready_mode = 0;
    @(negedge clk);
    chk("t5 new addr", imem_req_addr, 32'h0000_0040);
    wait_pop("t5 first", 32'h0000_0040, 32'h5A5A_C383);

    // T5b: PC wrap and unaligned redirect targets
    pulse_redirect(32'hFFFF_FFFC);
    wait_pop("wrap first", 32'hFFFF_FFFC, 32'hA5A5_3C3F);
    wait_pop("wrap second", 32'h0000_0000, 32'h5A5A_C3C3);
    pulse_redirect(32'h0000_0102);
    wait_pop("unaligned first", 32'h0000_0102, 32'h5A5A_C2C1);
    wait_pop("unaligned second", 32'h0000_0106, 32'h5A5A_C2C5);

    // T6: random ready/latency/redirect stress with async reset mid-burst
    lat_min = 1; lat_max = 3; ready_mode = 2;
    gap = 0;
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        @(posedge clk); #3;
        reset = 1'b1; redirect = 1'b0;
        @(negedge clk);
        chk_reset_state();
        @(posedge clk);
        @(posedge clk); #1 reset = 1'b0;
        gap = 0;
        @(negedge clk);
        chk("restart addr", imem_req_addr, RESET_PC);
        chk("restart if_valid", 32'(if_valid), 0);
      end
      @(posedge clk); #1;
      if_ready = ($urandom_range(9, 0) < 7);
      gap++;
      if (gap > 12 && $urandom_range(19, 0) == 0) begin
        redirect = 1'b1; redirect_pc = rtab[$urandom_range(3, 0)]; gap = 0;
      end else begin
        redirect = 1'b0;
      end
    end
    @(posedge clk); #1;
    redirect = 1'b0; if_ready = 1'b1; ready_mode = 0; lat_min = 1; lat_max = 1;
    repeat (14) @(posedge clk);
    pulse_redirect(32'h0000_0500);
    wait_pop("final first", 32'h0000_0500, 32'h5A5A_C6C3);
    wait_pop("final second", 32'h0000_0504, 32'h5A5A_C6C7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
